video_fetch_req: RTL and testbench

Initiator side of the video DRAM fetch path. Generates per-line video read requests to the DRAM arbiter and drives the byte-lane selects (f_sel/b_sel) that steer each returned 16-bit word into the 32-bit fetch buffer. Issues fetch_stb to move a completed group into the renderer's data register on the renderer's group tick. Sits between video timing (line_start, fetch_start) and the DRAM arbiter / fetch buffer.

---
 rtl/video_fetch_req_pkg.sv | 30 +++
 rtl/video_fetch_req_if.sv | 12 +
 rtl/video_fetch_req_addr.sv | 52 +++++
 rtl/video_fetch_req.sv | 186 ++++++++++++++++++
 tb/tb_video_fetch_req.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/video_fetch_req_pkg.sv
// Shared encodings for the video fetch request path: modes, FSM states and
// the fetch-buffer lane-select patterns used for each word of a group.
package video_fetch_pkg;

    typedef enum logic [1:0] {
        MODE_WORD  = 2'd0,
        MODE_DWORD = 2'd1,
        MODE_SPLIT = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_FULL = 2'd3
    } state_e;

    localparam logic [3:0] FSEL_LO   = 4'b0011;
    localparam logic [3:0] FSEL_HI   = 4'b1100;
    localparam logic [3:0] FSEL_B0   = 4'b0001;
    localparam logic [3:0] FSEL_B1   = 4'b0010;
    localparam logic [1:0] BSEL_WORD = 2'b10;

    // Reserved mode behaves as WORD.
    function automatic mode_e norm_mode(input logic [1:0] m);
        return (m == 2'(MODE_RSVD)) ? MODE_WORD : mode_e'(m);
    endfunction

endpackage

// File: rtl/video_fetch_req_if.sv
// Request/response handshake between the video fetch initiator and the DRAM arbiter.
interface video_fetch_req_if #(
    parameter int unsigned AW = 21
);
    logic          video_req;
    logic [AW-1:0] video_addr;
    logic          video_next;
    logic          video_strobe;

    modport master (output video_req, output video_addr, input video_next, input video_strobe);
    modport slave  (input video_req, input video_addr, output video_next, output video_strobe);
endinterface

// File: rtl/video_fetch_req_addr.sv
// Byte pointer for the current group plus the word addresses derived from it
// (second word, split-mode partner byte, and the first word of the next group).
module video_fetch_addr
    import video_fetch_pkg::*;
#(
    parameter int unsigned AW = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW:0]   load_base,
    input  logic          step,
    input  mode_e         mode,
    input  logic [AW:0]   split_ofs,
    output logic [AW-1:0] w0_addr_c,
    output logic [AW-1:0] w1_addr_c,
    output logic [AW-1:0] next_addr_c,
    output logic          w0_lsb_c,
    output logic          w1_lsb_c
);
    localparam int unsigned PW = AW + 1;

    logic [AW:0] ptr;
    logic [AW:0] sptr;
    logic [AW:0] nptr;
    logic [AW:0] inc;

    always_comb begin
        inc = PW'(2);
        case (mode)
            MODE_DWORD: inc = PW'(4);
            MODE_SPLIT: inc = PW'(1);
            default:    inc = PW'(2);
        endcase
    end

    // All sums are PW bits wide so they wrap naturally.
    assign sptr        = ptr + split_ofs;
    assign nptr        = ptr + inc;
    assign w0_addr_c   = ptr[AW:1];
    assign w1_addr_c   = (mode == MODE_SPLIT) ? sptr[AW:1] : ptr[AW:1] + AW'(1);
    assign next_addr_c = nptr[AW:1];
    assign w0_lsb_c    = ptr[0];
    assign w1_lsb_c    = sptr[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       ptr <= '0;
        else if (load) ptr <= load_base;
        else if (step) ptr <= nptr;
    end

endmodule

// File: rtl/video_fetch_req.sv
// Video fetch initiator: per-line DRAM read requests, fetch-buffer lane selects
// and the group hand-off strobe. Optional sticky underrun flag: VIDEO_FETCH_UNDERRUN_EN.
module video_fetch_req
    import video_fetch_pkg::*;
#(
    parameter int unsigned AW = 21,
    parameter int unsigned GW = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_start,
    input  logic [AW:0]       base_addr,
    input  logic [AW:0]       split_ofs,
    input  logic [GW-1:0]     grp_num,
    input  logic [1:0]        mode,
    input  logic              fetch_start,
    video_fetch_req_if.master vbus,
    output logic [3:0]        f_sel,
    output logic [1:0]        b_sel,
    output logic              fetch_stb,
    output logic              busy,
    output logic              underrun
);
    state_e        state;
    logic          w;
    logic [GW-1:0] grp_cnt;
    mode_e         mode_q;
    logic          req_q;
    logic [AW-1:0] addr_q;
    logic          pend_q;
    logic [AW:0]   pend_base;
    logic [GW-1:0] pend_grp;
    mode_e         pend_mode;

    logic          ld_c, step_c, word_done_c, last_c;
    logic [AW:0]   ld_base_c;
    logic [GW-1:0] ld_grp_c;
    mode_e         ld_mode_c;
    logic [3:0]    sel_f_c;
    logic [1:0]    sel_b_c;
    logic [AW-1:0] w0_addr_c, w1_addr_c, next_addr_c;
    logic          w0_lsb_c, w1_lsb_c;

    assign vbus.video_req  = req_q;
    assign vbus.video_addr = addr_q;

    // A line_start seen in DATA waits for the outstanding strobe before reloading.
    always_comb begin
        ld_base_c = pend_base;
        ld_grp_c  = pend_grp;
        ld_mode_c = pend_mode;
        ld_c      = (state == ST_DATA) && vbus.video_strobe && pend_q;
        if (line_start) begin
            ld_base_c = base_addr;
            ld_grp_c  = grp_num;
            ld_mode_c = norm_mode(mode);
            ld_c      = (state != ST_DATA) || vbus.video_strobe;
        end
        word_done_c = vbus.video_strobe &&
                      ((state == ST_DATA) || (state == ST_REQ && req_q && vbus.video_next));
        last_c      = (mode_q == MODE_WORD) || w;
        step_c      = (state == ST_FULL) && fetch_start && !ld_c;
    end

    always_comb begin
        sel_f_c = FSEL_LO;
        sel_b_c = BSEL_WORD;
        case (mode_q)
            MODE_DWORD: if (w) sel_f_c = FSEL_HI;
            MODE_SPLIT: begin
                if (w) begin
                    sel_f_c = FSEL_B1;
                    sel_b_c = {w1_lsb_c, b_sel[0]};
                end else begin
                    sel_f_c = FSEL_B0;
                    sel_b_c = {b_sel[1], w0_lsb_c};
                end
            end
            default: ;
        endcase
    end

    video_fetch_addr #(.AW(AW)) u_addr (
        .clk         (clk),
        .rst         (rst),
        .load        (ld_c),
        .load_base   (ld_base_c),
        .step        (step_c),
        .mode        (mode_q),
        .split_ofs   (split_ofs),
        .w0_addr_c   (w0_addr_c),
        .w1_addr_c   (w1_addr_c),
        .next_addr_c (next_addr_c),
        .w0_lsb_c    (w0_lsb_c),
        .w1_lsb_c    (w1_lsb_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            w         <= 1'b0;
            grp_cnt   <= '0;
            mode_q    <= MODE_WORD;
            req_q     <= 1'b0;
            addr_q    <= '0;
            pend_q    <= 1'b0;
            pend_base <= '0;
            pend_grp  <= '0;
            pend_mode <= MODE_WORD;
            f_sel     <= '0;
            b_sel     <= '0;
            fetch_stb <= 1'b0;
            busy      <= 1'b0;
        end else begin
            fetch_stb <= 1'b0;
            if (ld_c) begin
                grp_cnt <= ld_grp_c;
                mode_q  <= ld_mode_c;
                w       <= 1'b0;
                pend_q  <= 1'b0;
                req_q   <= 1'b0;
                addr_q  <= ld_base_c[AW:1];
                state   <= (ld_grp_c != '0) ? ST_REQ : ST_IDLE;
                busy    <= (ld_grp_c != '0);
            end else begin
                if (line_start) begin
                    pend_q    <= 1'b1;
                    pend_base <= base_addr;
                    pend_grp  <= grp_num;
                    pend_mode <= norm_mode(mode);
                end
                case (state)
                    ST_REQ: begin
                        if (!req_q) begin
                            req_q <= 1'b1;
                        end else if (vbus.video_next) begin
                            req_q <= 1'b0;
                            f_sel <= sel_f_c;
                            b_sel <= sel_b_c;
                            state <= ST_DATA;
                        end
                    end
                    ST_FULL: begin
                        if (fetch_start) begin
                            fetch_stb <= 1'b1;
                            grp_cnt   <= grp_cnt - GW'(1);
                            w         <= 1'b0;
                            if (grp_cnt != GW'(1)) begin
                                state  <= ST_REQ;
                                req_q  <= 1'b1;
                                addr_q <= next_addr_c;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: ;
                endcase
                // Word completion overrides the REQ->DATA step when next and strobe coincide.
                if (word_done_c) begin
                    if (last_c) begin
                        state <= ST_FULL;
                        req_q <= 1'b0;
                    end else begin
                        w      <= 1'b1;
                        state  <= ST_REQ;
                        req_q  <= 1'b1;
                        addr_q <= w1_addr_c;
                    end
                end
            end
        end
    end

`ifdef VIDEO_FETCH_UNDERRUN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       underrun <= 1'b0;
        else if (line_start)                           underrun <= 1'b0;
        else if (fetch_start && busy && state != ST_FULL) underrun <= 1'b1;
    end
`else
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_video_fetch_req.sv
// Directed bench for video_fetch_req: the bench plays the DRAM arbiter and the
// renderer, with expected request words queued when each line is started.
module tb_video_fetch_req;
    import video_fetch_pkg::*;

    localparam int unsigned AW = 21;
    localparam int unsigned GW = 9;
`ifdef VIDEO_FETCH_UNDERRUN_EN
    localparam logic UND = 1'b1;
`else
    localparam logic UND = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    fsel;
        logic [1:0]    bsel;
        logic [1:0]    bmask;
    } exp_t;

    exp_t sb[$];

    logic          clk = 1'b0;
    logic          rst;
    logic          line_start;
    logic [AW:0]   base_addr;
    logic [AW:0]   split_ofs;
    logic [GW-1:0] grp_num;
    logic [1:0]    mode;
    logic          fetch_start;
    logic [3:0]    f_sel;
    logic [1:0]    b_sel;
    logic          fetch_stb;
    logic          busy;
    logic          underrun;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    video_fetch_req_if #(.AW(AW)) vif ();

    video_fetch_req #(.AW(AW), .GW(GW)) dut (
        .clk         (clk),
        .rst         (rst),
        .line_start  (line_start),
        .base_addr   (base_addr),
        .split_ofs   (split_ofs),
        .grp_num     (grp_num),
        .mode        (mode),
        .fetch_start (fetch_start),
        .vbus        (vif),
        .f_sel       (f_sel),
        .b_sel       (b_sel),
        .fetch_stb   (fetch_stb),
        .busy        (busy),
        .underrun    (underrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [3:0] f, input logic [1:0] b,
                        input logic [1:0] m);
        exp_t e;
        e.addr = a; e.fsel = f; e.bsel = b; e.bmask = m;
        sb.push_back(e);
    endtask

    task automatic start_line(input logic [AW:0] base, input logic [GW-1:0] n, input logic [1:0] m);
        base_addr  = base;
        grp_num    = n;
        mode       = m;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
    endtask

    // Bounded wait for a request, then compare its address with the queue head.
    task automatic wait_req(input string tag);
        int n = 0;
        while (vif.video_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk({tag, "_req"}, 32'(vif.video_req), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) chk({tag, "_addr"}, 32'(vif.video_addr), 32'(sb[0].addr));
    endtask

    task automatic accept(input string tag);
        exp_t e;
        vif.video_next = 1'b1;
        step();
        vif.video_next = 1'b0;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_fsel"}, 32'(f_sel), 32'(e.fsel));
            if (e.bmask != 2'b00) chk({tag, "_bsel"}, 32'(b_sel & e.bmask), 32'(e.bsel));
        end
    endtask

    task automatic strobe();
        vif.video_strobe = 1'b1;
        step();
        vif.video_strobe = 1'b0;
    endtask

    task automatic serve(input string tag, input int gap);
        wait_req(tag);
        repeat (gap) step();
        accept(tag);
        strobe();
    endtask

    task automatic fetch(input string tag, input logic exp);
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        chk({tag, "_stb"}, 32'(fetch_stb), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        line_start = 1'b0; base_addr = '0; split_ofs = '0; grp_num = '0; mode = 2'd0;
        fetch_start = 1'b0; vif.video_next = 1'b0; vif.video_strobe = 1'b0;
        repeat (2) step();
        chk("rst_req", 32'(vif.video_req), 32'd0);
        chk("rst_fsel", 32'(f_sel), 32'd0);
        chk("rst_bsel", 32'(b_sel), 32'd0);
        chk("rst_stb", 32'(fetch_stb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        @(negedge clk) rst = 1'b0;
        step();

        // WORD, three groups
        for (int i = 0; i < 3; i++) push(AW'(32'h80 + i), FSEL_LO, BSEL_WORD, 2'b11);
        start_line(22'h000100, 9'd3, 2'(MODE_WORD));
        chk("word_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            serve($sformatf("word%0d", i), 2);
            fetch($sformatf("word%0d", i), 1'b1);
        end
        chk("word_busy_end", 32'(busy), 32'd0);
        step();
        chk("word_stb_one", 32'(fetch_stb), 32'd0);
        chk("word_underrun", 32'(underrun), 32'd0);

        // DWORD, one group
        push(AW'(32'h08), FSEL_LO, BSEL_WORD, 2'b11);
        push(AW'(32'h09), FSEL_HI, 2'b00, 2'b00);
        start_line(22'h000010, 9'd1, 2'(MODE_DWORD));
        serve("dw0", 1);
        serve("dw1", 0);
        chk("dw_full_busy", 32'(busy), 32'd1);
        fetch("dw", 1'b1);
        chk("dw_busy_end", 32'(busy), 32'd0);

        // SPLIT, two groups
        split_ofs = 22'h001800;
        push(AW'(32'h100), FSEL_B0, 2'b01, 2'b01);
        push(AW'(32'hD00), FSEL_B1, 2'b10, 2'b10);
        push(AW'(32'h101), FSEL_B0, 2'b00, 2'b01);
        push(AW'(32'hD01), FSEL_B1, 2'b00, 2'b10);
        start_line(22'h000201, 9'd2, 2'(MODE_SPLIT));
        for (int g = 0; g < 2; g++) begin
            serve($sformatf("sp%0d_w0", g), 1);
            serve($sformatf("sp%0d_w1", g), 1);
            fetch($sformatf("sp%0d", g), 1'b1);
        end
        chk("sp_busy_end", 32'(busy), 32'd0);

        // Early fetch_start: in DATA and on the last strobe, neither releases the group
        push(AW'(32'h0), FSEL_LO, BSEL_WORD, 2'b11);
        start_line(22'h000000, 9'd1, 2'(MODE_WORD));
        wait_req("ur");
        accept("ur");
        fetch("ur_in_data", 1'b0);
        chk("ur_flag_set", 32'(underrun), 32'(UND));
        vif.video_strobe = 1'b1;
        fetch_start = 1'b1;
        step();
        vif.video_strobe = 1'b0;
        fetch_start = 1'b0;
        chk("ur_last_strobe_stb", 32'(fetch_stb), 32'd0);
        fetch("ur_full", 1'b1);
        chk("ur_busy_end", 32'(busy), 32'd0);
        chk("ur_flag_sticky", 32'(underrun), 32'(UND));
        start_line(22'h000000, 9'd0, 2'(MODE_WORD));
        chk("ur_flag_clear", 32'(underrun), 32'd0);
        chk("grp0_idle", 32'(busy), 32'd0);

        // line_start during DATA is applied after the strobe; then async reset mid-REQ
        push(AW'(32'h80), FSEL_LO, BSEL_WORD, 2'b11);
        start_line(22'h000100, 9'd2, 2'(MODE_WORD));
        wait_req("pend_a");
        accept("pend_a");
        push(AW'(32'h200), FSEL_LO, BSEL_WORD, 2'b11);
        start_line(22'h000400, 9'd1, 2'(MODE_WORD));
        chk("pend_held_req", 32'(vif.video_req), 32'd0);
        strobe();
        chk("pend_busy", 32'(busy), 32'd1);
        wait_req("pend_b");
        #2 rst = 1'b1;
        #1;
        chk("arst_req", 32'(vif.video_req), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        sb.delete();
        @(negedge clk) rst = 1'b0;
        step();

        // Pointer wrap at the top of the byte space
        push(AW'(32'h1FFFFF), FSEL_LO, BSEL_WORD, 2'b11);
        push(AW'(32'h000000), FSEL_LO, BSEL_WORD, 2'b11);
        start_line(22'h3FFFFE, 9'd2, 2'(MODE_WORD));
        serve("wrap0", 0);
        fetch("wrap0", 1'b1);
        serve("wrap1", 0);
        fetch("wrap1", 1'b1);
        chk("wrap_busy_end", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
